// File: rtl/print_uart_pkg.sv
// Shared constants for the print UART transmitter.
// PRINT_UART_PARITY_EN adds an even-parity bit (8E1 frame).
package print_uart_pkg;

    localparam int DATA_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_STOP   = 3'd3;
`ifdef PRINT_UART_PARITY_EN
    localparam state_t ST_PARITY = 3'd4;
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/print_uart_if.sv
// Datapath-facing bundle of the print UART: strobe, data,
// overflow clear, and the serial pin plus status outputs.
interface print_uart_if;
    import print_uart_pkg::*;

    logic              pr_e;
    logic [DATA_W-1:0] pr_data;
    logic              ovf_clr;
    logic              tx;
    logic              busy;
    logic              fifo_full;
    logic              overflow;

    modport master (
        output pr_e, pr_data, ovf_clr,
        input  tx, busy, fifo_full, overflow
    );

    modport slave (
        input  pr_e, pr_data, ovf_clr,
        output tx, busy, fifo_full, overflow
    );

endinterface

// File: rtl/print_uart_fifo.sv
// Synchronous FIFO for queued print bytes; the pointer MSB
// separates full from empty, a pop frees room for a same-cycle push.
module print_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW])
                  && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + (AW+1)'(1);
            if (rd_en) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/print_uart_tx.sv
// Print-line UART transmitter: queues PR_E bytes, sends 8N1 LSB first.
// PRINT_UART_PARITY_EN inserts an even-parity bit before the stop bit.
module print_uart_tx
    import print_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    print_uart_if.slave  uart
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
`ifdef PRINT_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              pop;
    logic              bit_end;
    logic              drop;
    logic [DATA_W-1:0] f_dout;
    logic              f_full;
    logic              f_empty;

    print_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (uart.pr_e),
        .pop_i   (pop),
        .din_i   (uart.pr_data),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    assign bit_end = (baud_q == BAUD_LAST);
    assign drop    = uart.pr_e & f_full & ~pop;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef PRINT_UART_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE)
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        // tx_d follows the next state so the pin changes with it
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!f_empty) begin
                    pop     = 1'b1;
                    shift_d = f_dout;
`ifdef PRINT_UART_PARITY_EN
                    par_d   = ^f_dout;
`endif
                    baud_d  = '0;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef PRINT_UART_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef PRINT_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // a drop beats a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (uart.ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef PRINT_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
`ifdef PRINT_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uart.tx        = tx_q;
    assign uart.busy      = (state_q != ST_IDLE) | ~f_empty;
    assign uart.fifo_full = f_full;
    assign uart.overflow  = ovf_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Bench for print_uart_tx: table of single-byte frames plus
// burst/overflow, push-on-pop and mid-frame reset sequences.
module tb_print_uart_tx;
    import print_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef PRINT_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FCLK = FB * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop_ok;
        logic       clean;
        int         start;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    print_uart_if uart();

    print_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .uart (uart)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // line monitor: decodes frames from tx, one sample per cycle
    frame_t frames[$];
    frame_t cur;
    logic   mon_act = 1'b0;
    logic   bitval;
    int     k;
    int     mb;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && uart.tx === 1'b0) begin
                mon_act     = 1'b1;
                k           = 0;
                cur.start   = cyc;
                cur.clean   = 1'b1;
                cur.data    = '0;
                cur.par     = 1'b0;
                cur.stop_ok = 1'b0;
            end
            if (mon_act) begin
                mb = k / CPB;
                if (k % CPB == 0) bitval = uart.tx;
                else if (uart.tx !== bitval) cur.clean = 1'b0;
                if (k % CPB == CPB / 2) begin
                    if (mb == 0) begin
                        if (uart.tx !== 1'b0) cur.clean = 1'b0;
                    end else if (mb <= 8) begin
                        cur.data[mb-1] = uart.tx;
                    end else if (mb == FB - 1) begin
                        cur.stop_ok = uart.tx;
                    end else begin
                        cur.par = uart.tx;
                    end
                end
                if (k == FCLK - 1) begin
                    frames.push_back(cur);
                    mon_act = 1'b0;
                end
                k++;
            end
        end
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        uart.pr_e    = 1'b1;
        uart.pr_data = d;
        @(posedge clk);
        #1;
        uart.pr_e    = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string nm);
        int t = 0;
        while (frames.size() < n && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({nm, "_timeout"}, 32'(frames.size() >= n), 1);
    endtask

    vec_t vt[6];
    logic [7:0] burst_exp[6];

    initial begin
        int n0;
        int p;
        int lowcnt;
        frame_t f;

        vt[0] = '{8'hA5, 1'b0};
        vt[1] = '{8'h07, 1'b1};
        vt[2] = '{8'h00, 1'b0};
        vt[3] = '{8'hFF, 1'b0};
        vt[4] = '{8'h80, 1'b1};
        vt[5] = '{8'h3C, 1'b0};
        burst_exp[0] = 8'h5A;
        burst_exp[1] = 8'h01;
        burst_exp[2] = 8'h02;
        burst_exp[3] = 8'h03;
        burst_exp[4] = 8'h04;
        burst_exp[5] = 8'h77;

        uart.pr_e    = 1'b0;
        uart.pr_data = '0;
        uart.ovf_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",   uart.tx,        1);
        check("rst_busy", uart.busy,      0);
        check("rst_full", uart.fifo_full, 0);
        check("rst_ovf",  uart.overflow,  0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single frames from the table
        for (int i = 0; i < 6; i++) begin
            n0 = frames.size();
            p  = cyc;
            push(vt[i].data);
            check("vec_busy_head", uart.busy, 1);
            wait_frames(n0 + 1, "vec");
            if (frames.size() > n0) begin
                f = frames[n0];
                check("vec_busy_tail", uart.busy, 1);
                check("vec_end_cyc", cyc, p + 1 + FCLK);
                check("vec_data", f.data, vt[i].data);
                check("vec_start", f.start, p + 2);
                check("vec_shape", {f.clean, f.stop_ok}, 2'b11);
`ifdef PRINT_UART_PARITY_EN
                check("vec_par", f.par, vt[i].par);
`endif
                @(negedge clk);
                #1;
                check("vec_busy_drop", uart.busy, 0);
                check("vec_tx_idle", uart.tx, 1);
            end
            @(posedge clk);
            #1;
        end

        // burst behind an active frame, overflow, push on pop
        n0 = frames.size();
        p  = cyc;
        push(8'h5A);
        repeat (3) @(posedge clk);
        #1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("burst_full", uart.fifo_full, 1);
        check("burst_ovf0", uart.overflow, 0);
        push(8'hFF);
        check("drop_ovf", uart.overflow, 1);
        check("drop_full", uart.fifo_full, 1);
        uart.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        uart.ovf_clr = 1'b0;
        check("ovf_clr", uart.overflow, 0);
        while (cyc < p + 2 + FCLK) begin
            @(posedge clk);
            #1;
        end
        check("pp_full_pre", uart.fifo_full, 1);
        push(8'h77);
        check("pp_ovf", uart.overflow, 0);
        check("pp_full_post", uart.fifo_full, 1);
        wait_frames(n0 + 6, "burst");
        for (int j = 0; j < 6; j++) begin
            if (frames.size() > n0 + j) begin
                f = frames[n0 + j];
                check("burst_data", f.data, burst_exp[j]);
                check("burst_start", f.start,
                      p + 2 + j * (FCLK + 1));
                check("burst_shape", {f.clean, f.stop_ok}, 2'b11);
            end
        end
        repeat (10) @(negedge clk);
        #1;
        check("burst_count", frames.size(), n0 + 6);
        check("burst_idle", uart.busy, 0);

        // reset during DATA bit 3, with a second byte queued
        @(posedge clk);
        #1;
        n0 = frames.size();
        p  = cyc;
        push(8'h00);
        push(8'h33);
        while (cyc < p + 19) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        check("pre_rst_tx", uart.tx, 0);
        rst = 1'b1;
        #1;
        check("async_rst_tx", uart.tx, 1);
        check("async_rst_busy", uart.busy, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_busy", uart.busy, 0);
        check("post_rst_full", uart.fifo_full, 0);
        lowcnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (uart.tx !== 1'b1) lowcnt++;
        end
        #1;
        check("post_rst_quiet", lowcnt, 0);
        check("post_rst_frames", frames.size(), n0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/print_uart_tx.md
Name: print_uart_tx

Overview:
- Consumer end of the control unit's print line (PR_E).
- On each PR_E strobe, captures the 8-bit accumulator value into a small FIFO.
- Serialises queued bytes onto a UART TX pin, 8N1, LSB first.
- Sits between the datapath (Acc, PR_E) and the board-level serial pin, so back-to-back print instructions do not stall the core.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, 4: number of queued print bytes; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pr_e  in  1  print strobe from the control unit, one cycle wide per print instruction.
- pr_data  in  8  accumulator value, sampled in the same cycle as pr_e.
- ovf_clr  in  1  synchronous clear of the sticky overflow flag.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky: a print byte was dropped.

Behaviour:
- Reset values:
  - tx=1, busy=0, fifo_full=0, overflow=0.
  - FIFO empty; pointers 0; bit counter 0; baud counter 0; state IDLE.
- Asserting rst mid-frame forces tx=1 immediately, without waiting for a clock edge. The partial frame and all queued bytes are discarded.
- Push:
  - When pr_e=1 and the FIFO is not full, pr_data is written at the clock edge.
  - When pr_e=1 and the FIFO is full, the byte is dropped and overflow is set at the clock edge.
  - If the FIFO is full but a pop occurs in the same cycle, the push is accepted and overflow stays unchanged.
- overflow:
  - Cleared by ovf_clr=1 at the clock edge.
  - If ovf_clr and a drop occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE spends exactly one cycle when the FIFO is non-empty. The inter-frame gap is therefore stop bit + 1 clk.
- Latency: with pr_e high in cycle N into an empty FIFO and the FSM in IDLE:
  - FIFO non-empty from cycle N+1.
  - tx falls in cycle N+2.
  - Total frame length is 10·CLKS_PER_BIT cycles.
- Baud counter:
  - Counts from 0 to CLKS_PER_BIT-1.
  - Width is clog2(CLKS_PER_BIT); wraps to 0 on each bit boundary.
- FIFO pointers:
  - Width clog2(FIFO_DEPTH)+1; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- busy = (state != IDLE) | !fifo_empty.
- tx is driven from a register, not combinationally from state, so the line is glitch-free.

Optional Feature:
- Macro: PRINT_UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
- When undefined: no PARITY state and no parity logic; 10-bit 8N1 frame.

Decomposition:
- Shared package print_uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP/PARITY);
  - the DATA_W=8 constant;
  - frame-length constants.
- One natural sub-module: print_fifo, a synchronous FIFO parameterised by width and depth. It provides push, pop, full, empty and dout (registered head).
- The FSM, shift register and baud counter live in the top module.

Test Plan:
- Single byte, CLKS_PER_BIT=4: pr_e with pr_data=0xA5 in cycle 10 → tx low at cycle 12, then bits 1,0,1,0,0,1,0,1 each held 4 cycles, stop high. busy drops at cycle 52.
- Burst, CLKS_PER_BIT=4, FIFO_DEPTH=4: pr_e on 4 consecutive cycles with 0x01..0x04 → fifo_full asserts once the FIFO holds 4 entries. Four frames go out in order; gap between frames is 5 cycles of tx=1. overflow stays 0.
- Overflow: FIFO full with a frame mid-transmission, pr_e with 0xFF → byte dropped and overflow=1. ovf_clr in a later cycle → overflow=0. 0xFF never appears on tx.
- Simultaneous pop and push: FIFO full, push on the same cycle the FSM pops from IDLE → push accepted; overflow stays 0; the byte is transmitted later.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 before the next clk edge. After release, busy=0 and fifo_full=0, and no residual frame is sent.
- With PRINT_UART_PARITY_EN, byte 0x07 (three ones) → parity bit 1, frame length 44 cycles at CLKS_PER_BIT=4.
